// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// cpu_ctrl_pkg : opcodes, ALU encodings, sequencer states and IR field map
//                shared by the hardwired control unit.
// Revision     : 1.0
// ============================================================================
package cpu_ctrl_pkg;

    localparam int OP_W  = 5;
    localparam int ALU_W = 5;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;
    localparam int IR_C_MSB  = 18;
    localparam int IR_C_LSB  = 0;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    localparam logic [ALU_W-1:0] ALU_NONE = 5'b00000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 5'b00011;
    localparam logic [ALU_W-1:0] ALU_AND  = 5'b01001;
    localparam logic [ALU_W-1:0] ALU_OR   = 5'b01010;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_T0    = 4'd1,
        ST_T1    = 4'd2,
        ST_T2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_HALT  = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU3    = 4'd0,
        CLS_UNARY   = 4'd1,
        CLS_IMM     = 4'd2,
        CLS_MULDIV  = 4'd3,
        CLS_LD      = 4'd4,
        CLS_LDI     = 4'd5,
        CLS_ST      = 4'd6,
        CLS_NOP     = 4'd7,
        CLS_HALT    = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_t;

    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic zhigh_out;
        logic mdr_out;
        logic c_out;
        logic ba_out;
        logic r_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic r_in;
        logic hi_in;
        logic lo_in;
        logic zlow_in;
        logic zhigh_in;
        logic gra;
        logic grb;
        logic grc;
        logic inc_pc;
        logic read;
        logic write;
        logic run;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// cpu_ctrl_decode : combinational opcode -> instruction class and ALU_op map.
// Revision        : 1.0
// ============================================================================
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = OP_W,
    parameter int ALUW = ALU_W
) (
    input  logic [OPW-1:0]  opcode_i,
    output logic [3:0]      class_o,
    output logic [ALUW-1:0] alu_op_o
);

    instr_class_t cls;
    logic [ALUW-1:0] alu_op;

    always_comb begin
        cls    = CLS_ILLEGAL;
        alu_op = ALUW'(ALU_NONE);
        case (opcode_i)
            OP_LD: begin
                cls    = CLS_LD;
                alu_op = ALUW'(ALU_ADD);
            end
            OP_LDI: begin
                cls    = CLS_LDI;
                alu_op = ALUW'(ALU_ADD);
            end
            OP_ST: begin
                cls    = CLS_ST;
                alu_op = ALUW'(ALU_ADD);
            end
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
                cls    = CLS_ALU3;
                alu_op = ALUW'(opcode_i);
            end
            // Immediate forms reuse the register-register ALU operation.
            OP_ADDI: begin
                cls    = CLS_IMM;
                alu_op = ALUW'(ALU_ADD);
            end
            OP_ANDI: begin
                cls    = CLS_IMM;
                alu_op = ALUW'(ALU_AND);
            end
            OP_ORI: begin
                cls    = CLS_IMM;
                alu_op = ALUW'(ALU_OR);
            end
            OP_MUL, OP_DIV: begin
                cls    = CLS_MULDIV;
                alu_op = ALUW'(opcode_i);
            end
            OP_NEG, OP_NOT: begin
                cls    = CLS_UNARY;
                alu_op = ALUW'(opcode_i);
            end
            OP_NOP:  cls = CLS_NOP;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_ILLEGAL;
        endcase
    end

    assign class_o  = cls;
    assign alu_op_o = alu_op;

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// cpu_control_unit : hardwired fetch/decode/execute sequencer that drives the
//                    single-bus datapath strobes, with memory ready handshake.
// Revision         : 1.0
// ============================================================================
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = OP_W,
    parameter int ALUW = ALU_W
) (
    input  logic            Clock_i,
    input  logic            Clear_i,
    input  logic [31:0]     IR_i,
    input  logic            MemRdy_i,
    input  logic            Stop_i,
    output logic            PCout_o,
    output logic            Zlowout_o,
    output logic            ZHighout_o,
    output logic            MDRout_o,
    output logic            Cout_o,
    output logic            BAout_o,
    output logic            Rout_o,
    output logic            MARin_o,
    output logic            PCin_o,
    output logic            MDRin_o,
    output logic            IRin_o,
    output logic            Yin_o,
    output logic            Rin_o,
    output logic            HIin_o,
    output logic            LOin_o,
    output logic            ZLowIn_o,
    output logic            ZHighIn_o,
    output logic            Gra_o,
    output logic            Grb_o,
    output logic            Grc_o,
    output logic            IncPC_o,
    output logic            Read_o,
    output logic            Write_o,
    output logic [ALUW-1:0] ALU_op_o,
    output logic            Run_o
);

    state_t          state_q;
    state_t          state_d;
    state_t          done_state;
    instr_class_t    cls;
    logic [3:0]      dec_class;
    logic [ALUW-1:0] dec_alu_op;
    logic [OPW-1:0]  opcode;
    ctrl_t           ctrl;
    logic [ALUW-1:0] alu_op;
    logic            unused_ir;

    assign opcode = IR_i[IR_OP_MSB -: OPW];
    // Operand fields are consumed by the external register select/encode logic.
    assign unused_ir = ^{IR_i[IR_RA_MSB:IR_RA_LSB], IR_i[IR_RB_MSB:IR_RB_LSB],
                         IR_i[IR_RC_MSB:IR_RC_LSB], IR_i[IR_C_MSB:IR_C_LSB]};

    cpu_ctrl_decode #(
        .OPW  (OPW),
        .ALUW (ALUW)
    ) u_decode (
        .opcode_i (opcode),
        .class_o  (dec_class),
        .alu_op_o (dec_alu_op)
    );

    assign cls = instr_class_t'(dec_class);

    always_ff @(posedge Clock_i or negedge Clear_i) begin
        if (!Clear_i) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        done_state = Stop_i ? ST_HALT : ST_T0;
        state_d    = state_q;
        case (state_q)
            ST_RESET: state_d = done_state;
            ST_T0:    state_d = ST_T1;
            ST_T1:    state_d = MemRdy_i ? ST_T2 : ST_T1;
            ST_T2:    state_d = ST_T3;
            ST_T3: begin
                case (cls)
                    CLS_NOP:               state_d = done_state;
                    CLS_HALT, CLS_ILLEGAL: state_d = ST_HALT;
                    default:               state_d = ST_T4;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_UNARY: state_d = done_state;
                    CLS_ALU3, CLS_IMM, CLS_MULDIV,
                    CLS_LDI, CLS_LD, CLS_ST: state_d = ST_T5;
                    default:   state_d = ST_HALT;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_ALU3, CLS_IMM, CLS_LDI: state_d = done_state;
                    CLS_MULDIV, CLS_LD, CLS_ST: state_d = ST_T6;
                    default:                    state_d = ST_HALT;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CLS_MULDIV: state_d = done_state;
                    CLS_LD:     state_d = MemRdy_i ? ST_T7 : ST_T6;
                    CLS_ST:     state_d = ST_T7;
                    default:    state_d = ST_HALT;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CLS_LD:  state_d = done_state;
                    CLS_ST:  state_d = MemRdy_i ? done_state : ST_T7;
                    default: state_d = ST_HALT;
                endcase
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_HALT;
        endcase
    end

    always_comb begin
        ctrl     = '0;
        alu_op   = '0;
        ctrl.run = (state_q != ST_RESET) && (state_q != ST_HALT);
        if ((state_q == ST_T3) || (state_q == ST_T4) || (state_q == ST_T5) ||
            (state_q == ST_T6) || (state_q == ST_T7)) begin
            alu_op = dec_alu_op;
        end
        case (state_q)
            ST_T0: begin
                ctrl.pc_out  = 1'b1;
                ctrl.mar_in  = 1'b1;
                ctrl.inc_pc  = 1'b1;
                ctrl.zlow_in = 1'b1;
            end
            // Read stays up while waiting; latches fire only in the ready cycle.
            ST_T1: begin
                ctrl.read     = 1'b1;
                ctrl.mdr_in   = MemRdy_i;
                ctrl.zlow_out = MemRdy_i;
                ctrl.pc_in    = MemRdy_i;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_ALU3, CLS_IMM: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.zlow_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_ALU3: begin
                        ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.zlow_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CLS_IMM, CLS_LDI, CLS_LD, CLS_ST: begin
                        ctrl.c_out = 1'b1; ctrl.zlow_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.grb      = 1'b1; ctrl.r_out   = 1'b1;
                        ctrl.zhigh_in = 1'b1; ctrl.zlow_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CLS_ALU3, CLS_IMM, CLS_LDI: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (cls)
                    CLS_MULDIV: begin
                        ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
                    end
                    CLS_LD: begin
                        ctrl.read = 1'b1; ctrl.mdr_in = MemRdy_i;
                    end
                    CLS_ST: begin
                        ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (cls)
                    CLS_LD: begin
                        ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
                    end
                    CLS_ST:  ctrl.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign PCout_o    = ctrl.pc_out;
    assign Zlowout_o  = ctrl.zlow_out;
    assign ZHighout_o = ctrl.zhigh_out;
    assign MDRout_o   = ctrl.mdr_out;
    assign Cout_o     = ctrl.c_out;
    assign BAout_o    = ctrl.ba_out;
    assign Rout_o     = ctrl.r_out;
    assign MARin_o    = ctrl.mar_in;
    assign PCin_o     = ctrl.pc_in;
    assign MDRin_o    = ctrl.mdr_in;
    assign IRin_o     = ctrl.ir_in;
    assign Yin_o      = ctrl.y_in;
    assign Rin_o      = ctrl.r_in;
    assign HIin_o     = ctrl.hi_in;
    assign LOin_o     = ctrl.lo_in;
    assign ZLowIn_o   = ctrl.zlow_in;
    assign ZHighIn_o  = ctrl.zhigh_in;
    assign Gra_o      = ctrl.gra;
    assign Grb_o      = ctrl.grb;
    assign Grc_o      = ctrl.grc;
    assign IncPC_o    = ctrl.inc_pc;
    assign Read_o     = ctrl.read;
    assign Write_o    = ctrl.write;
    assign Run_o      = ctrl.run;
    assign ALU_op_o   = alu_op;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// tb_cpu_control_unit : directed + randomized bench; expected strobes come from
//                       a per-instruction step table built from opcode class.
// Revision            : 1.0
// ============================================================================
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        Clear, MemRdy, Stop;
    logic [31:0] IR;
    logic PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout;
    logic MARin, PCin, MDRin, IRin, Yin, Rin, HIin, LOin, ZLowIn, ZHighIn;
    logic Gra, Grb, Grc, IncPC, Read, Write, Run;
    logic [4:0]  ALU_op;
    logic [23:0] obs_ctrl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_control_unit dut (
        .Clock_i (clk),      .Clear_i (Clear),     .IR_i (IR),
        .MemRdy_i (MemRdy),  .Stop_i (Stop),
        .PCout_o (PCout),    .Zlowout_o (Zlowout), .ZHighout_o (ZHighout),
        .MDRout_o (MDRout),  .Cout_o (Cout),       .BAout_o (BAout),
        .Rout_o (Rout),      .MARin_o (MARin),     .PCin_o (PCin),
        .MDRin_o (MDRin),    .IRin_o (IRin),       .Yin_o (Yin),
        .Rin_o (Rin),        .HIin_o (HIin),       .LOin_o (LOin),
        .ZLowIn_o (ZLowIn),  .ZHighIn_o (ZHighIn), .Gra_o (Gra),
        .Grb_o (Grb),        .Grc_o (Grc),         .IncPC_o (IncPC),
        .Read_o (Read),      .Write_o (Write),     .ALU_op_o (ALU_op),
        .Run_o (Run)
    );

    assign obs_ctrl = {PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout,
                       MARin, PCin, MDRin, IRin, Yin, Rin, HIin, LOin, ZLowIn,
                       ZHighIn, Gra, Grb, Grc, IncPC, Read, Write, Run};

    localparam logic [23:0] PCOUT    = 24'd1 << 23;
    localparam logic [23:0] ZLOWOUT  = 24'd1 << 22;
    localparam logic [23:0] ZHIGHOUT = 24'd1 << 21;
    localparam logic [23:0] MDROUT   = 24'd1 << 20;
    localparam logic [23:0] COUT     = 24'd1 << 19;
    localparam logic [23:0] BAOUT    = 24'd1 << 18;
    localparam logic [23:0] ROUT     = 24'd1 << 17;
    localparam logic [23:0] MARIN    = 24'd1 << 16;
    localparam logic [23:0] PCIN     = 24'd1 << 15;
    localparam logic [23:0] MDRIN    = 24'd1 << 14;
    localparam logic [23:0] IRIN     = 24'd1 << 13;
    localparam logic [23:0] YIN      = 24'd1 << 12;
    localparam logic [23:0] RIN      = 24'd1 << 11;
    localparam logic [23:0] HIIN     = 24'd1 << 10;
    localparam logic [23:0] LOIN     = 24'd1 << 9;
    localparam logic [23:0] ZLOWIN   = 24'd1 << 8;
    localparam logic [23:0] ZHIGHIN  = 24'd1 << 7;
    localparam logic [23:0] GRA      = 24'd1 << 6;
    localparam logic [23:0] GRB      = 24'd1 << 5;
    localparam logic [23:0] GRC      = 24'd1 << 4;
    localparam logic [23:0] INCPC    = 24'd1 << 3;
    localparam logic [23:0] READ     = 24'd1 << 2;
    localparam logic [23:0] WRITE    = 24'd1 << 1;
    localparam logic [23:0] RUN      = 24'd1;

    typedef struct {
        logic [23:0] ctrl;
        logic [4:0]  alu;
        bit          rdy;
    } step_t;

    step_t exp_q[$];

    int unsigned legal_ops [19] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13,
                                    14, 15, 16, 17, 26};
    int unsigned ill_ops [12]   = '{18, 19, 20, 21, 22, 23, 24, 25, 28, 29, 30, 31};

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [23:0] ec, input logic [4:0] ea);
        checks++;
        assert ({obs_ctrl, ALU_op} === {ec, ea}) else begin
            failures++;
            $error("FAIL %s: ctrl=%h alu=%b, expected ctrl=%h alu=%b",
                   tag, obs_ctrl, ALU_op, ec, ea);
        end
    endtask

    // ALU operation the datapath must see once the IR is valid.
    function automatic logic [4:0] exp_alu(input logic [4:0] op);
        if (op inside {[5'd3:5'd10], [5'd14:5'd17]}) return op;
        if (op inside {5'd0, 5'd1, 5'd2, 5'd11})     return 5'd3;
        if (op == 5'd12)                             return 5'd9;
        if (op == 5'd13)                             return 5'd10;
        return 5'd0;
    endfunction

    task automatic push(input logic [23:0] c, input logic [4:0] a, input bit r);
        step_t s;
        s.ctrl = c | RUN;
        s.alu  = a;
        s.rdy  = r;
        exp_q.push_back(s);
    endtask

    // One entry per clock cycle; w1/w2 are the not-ready cycles of each access.
    task automatic build(input logic [31:0] ir, input int w1, input int w2);
        logic [4:0] op;
        logic [4:0] a;
        op = ir[31:27];
        a  = exp_alu(op);
        exp_q.delete();
        push(PCOUT | MARIN | INCPC | ZLOWIN, 5'd0, rnd());
        repeat (w1) push(READ, 5'd0, 1'b0);
        push(READ | MDRIN | ZLOWOUT | PCIN, 5'd0, 1'b1);
        push(MDROUT | IRIN, 5'd0, rnd());
        if (op inside {[5'd3:5'd10]}) begin
            push(GRB | ROUT | YIN, a, rnd());
            push(GRC | ROUT | ZLOWIN, a, rnd());
            push(ZLOWOUT | GRA | RIN, a, rnd());
        end else if (op inside {[5'd11:5'd13]}) begin
            push(GRB | ROUT | YIN, a, rnd());
            push(COUT | ZLOWIN, a, rnd());
            push(ZLOWOUT | GRA | RIN, a, rnd());
        end else if (op inside {5'd14, 5'd15}) begin
            push(GRA | ROUT | YIN, a, rnd());
            push(GRB | ROUT | ZHIGHIN | ZLOWIN, a, rnd());
            push(ZLOWOUT | LOIN, a, rnd());
            push(ZHIGHOUT | HIIN, a, rnd());
        end else if (op inside {5'd16, 5'd17}) begin
            push(GRB | ROUT | ZLOWIN, a, rnd());
            push(ZLOWOUT | GRA | RIN, a, rnd());
        end else if (op inside {5'd0, 5'd1, 5'd2}) begin
            push(GRB | BAOUT | YIN, a, rnd());
            push(COUT | ZLOWIN, a, rnd());
            if (op == 5'd1) begin
                push(ZLOWOUT | GRA | RIN, a, rnd());
            end else begin
                push(ZLOWOUT | MARIN, a, rnd());
                if (op == 5'd0) begin
                    repeat (w2) push(READ, a, 1'b0);
                    push(READ | MDRIN, a, 1'b1);
                    push(MDROUT | GRA | RIN, a, rnd());
                end else begin
                    push(GRA | ROUT | MDRIN, a, rnd());
                    repeat (w2) push(WRITE, a, 1'b0);
                    push(WRITE, a, 1'b1);
                end
            end
        end else begin
            push(24'd0, 5'd0, rnd());
        end
    endtask

    // Drives and checks one instruction; limit>=0 stops after that many cycles.
    task automatic run(input string tag, input logic [31:0] ir, input int w1,
                       input int w2, input bit stop, input int limit);
        build(ir, w1, w2);
        for (int i = 0; i < exp_q.size() && (limit < 0 || i < limit); i++) begin
            @(negedge clk);
            if (i == 0) IR = ir;
            MemRdy = exp_q[i].rdy;
            Stop   = stop;
            #1;
            check($sformatf("%s_c%0d", tag, i), exp_q[i].ctrl, exp_q[i].alu);
        end
    endtask

    task automatic halt_hold(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            Stop   = 1'b0;
            MemRdy = rnd();
            #1;
            check(tag, 24'd0, 5'd0);
        end
    endtask

    task automatic do_reset(input bit stop);
        Clear = 1'b0;
        Stop  = stop;
        #1;
        check("reset_async", 24'd0, 5'd0);
        @(negedge clk);
        #1;
        check("reset_low", 24'd0, 5'd0);
        Clear = 1'b1;
    endtask

    initial begin
        logic [31:0] ir;
        Clear  = 1'b0;
        MemRdy = 1'b0;
        Stop   = 1'b0;
        IR     = 32'd0;

        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_hold", 24'd0, 5'd0);
        end
        Clear = 1'b1;

        run("add",  32'h1A920000, 0, 0, 1'b0, -1);
        run("ld",   32'h00800065, 2, 3, 1'b0, -1);
        run("mul",  32'h71880000, 0, 0, 1'b0, -1);
        run("st",   32'h10800065, 0, 4, 1'b0, -1);
        run("nop",  32'hD0000000, 1, 0, 1'b0, -1);
        run("ldi",  32'h08800065, 0, 0, 1'b0, -1);
        run("neg",  32'h80880000, 0, 0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            ir = $urandom();
            ir[31:27] = 5'(legal_ops[$urandom_range(0, 18)]);
            run($sformatf("rnd%0d_op%0d", n, ir[31:27]), ir,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, -1);
        end

        // Clear mid-T4 must zero every strobe without waiting for a clock edge.
        run("add_clr", 32'h1A920000, 0, 0, 1'b0, 5);
        Clear = 1'b0;
        #1;
        check("clear_mid_t4", 24'd0, 5'd0);
        @(negedge clk);
        #1;
        check("clear_mid_hold", 24'd0, 5'd0);
        Clear = 1'b1;
        run("add_after_clr", 32'h1A920000, 0, 0, 1'b0, -1);

        run("add_stop", 32'h1A920000, 1, 0, 1'b1, -1);
        halt_hold("stop_halt", 4);
        do_reset(1'b0);

        run("halt", 32'hD8000000, 0, 0, 1'b0, -1);
        halt_hold("halt_op", 4);
        do_reset(1'b0);

        run("illegal31", 32'hF8000000, 0, 0, 1'b0, -1);
        halt_hold("illegal31_halt", 3);
        do_reset(1'b0);

        ir = $urandom();
        ir[31:27] = 5'(ill_ops[$urandom_range(0, 11)]);
        run("illegal_rnd", ir, $urandom_range(0, 2), 0, 1'b0, -1);
        halt_hold("illegal_rnd_halt", 3);

        do_reset(1'b1);
        halt_hold("reset_stop_halt", 3);
        do_reset(1'b0);
        run("nop_recover", 32'hD0000000, 0, 0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_control_unit.md
# cpu_control_unit

Hardwired control unit for the single-bus datapath. It replaces hand-driven control strobes with a sequencer. Each instruction is fetched through the PC/MAR/MDR/IR path, its opcode is decoded, and a cycle-exact sequence of register-select, bus-driver, latch-enable and ALU-operation signals is driven into the datapath. Memory accesses use a ready handshake.

## Interface
- OPW, 5, opcode width (IR[31:27])
- ALUW, 5, width of ALU_op (datapath ALU encoding)
- Clock  in  1  rising-edge clock
- Clear  in  1  asynchronous, active-low reset
- IR  in  32  instruction register contents (valid from T3)
- MemRdy  in  1  memory ready; completes a Read or Write in the cycle it is high
- Stop  in  1  halt request, honoured at instruction boundary
- PCout, Zlowout, ZHighout, MDRout, Cout, BAout, Rout  out  1 each  bus drivers
- MARin, PCin, MDRin, IRin, Yin, Rin, HIin, LOin, ZLowIn, ZHighIn  out  1 each  latch enables
- Gra, Grb, Grc  out  1 each  select IR Ra/Rb/Rc field for the external select/encode logic
- IncPC, Read, Write  out  1 each  ALU PC+1 mode, memory read, memory write
- ALU_op  out  ALUW  ALU operation
- Run  out  1  high while executing, low in HALT and RESET

## Operation
- IR fields: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15], C[18:0].
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, nop 11010, halt 11011. All others are illegal and go to HALT.
- ALU_op equals the opcode for ALU instructions. addi/andi/ori use add/and/or. ld/ldi/st use add (00011). ALU_op is 0 otherwise.
- States: RESET, T0–T7, HALT. Sequence per step:
- Fetch:
  - T0: PCout MARin IncPC ZLowIn
  - T1: Read MDRin. Hold T1 until MemRdy. Zlowout PCin only in the completing cycle.
  - T2: MDRout IRin
- Reg-reg ALU: T3 Grb Rout Yin; T4 Grc Rout ZLowIn; T5 Zlowout Gra Rin.
- neg/not: T3 Grb Rout ZLowIn; T4 Zlowout Gra Rin.
- Immediate: T3 Grb Rout Yin; T4 Cout ZLowIn; T5 Zlowout Gra Rin.
- mul/div: T3 Gra Rout Yin; T4 Grb Rout ZHighIn ZLowIn; T5 Zlowout LOin; T6 ZHighout HIin.
- ldi: T3 Grb BAout Yin; T4 Cout ZLowIn; T5 Zlowout Gra Rin.
- ld: T3–T4 as ldi; T5 Zlowout MARin; T6 Read MDRin, held until MemRdy; T7 MDRout Gra Rin.
- st: T3–T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write, held until MemRdy.
- nop: T3 returns to T0. halt: T3 goes to HALT.
- Transitions:
  - The last step of any instruction goes to T0, or to HALT if Stop=1 on that edge.
  - RESET goes to T0 on the first edge after Clear deasserts, or to HALT if Stop=1.
  - HALT exits only via Clear.

## Timing
- Moore outputs decoded from the registered state. In T1, T6 (ld) and T7 (st), the completion qualifiers additionally depend on MemRdy.
- Reset: state=RESET. All outputs 0, including ALU_op=0 and Run=0, immediately on Clear low, even mid-instruction.
- Latency with MemRdy always 1:
  - nop 4 cycles
  - neg/not 5
  - reg-reg ALU, immediate, ldi 6
  - mul/div 7
  - ld/st 8
- Each low MemRdy cycle adds exactly one cycle.
- Read/Write stay asserted continuously through wait cycles. Latches fire only once per access.
- Run=1 in T0–T7.

## Structure
- Package cpu_ctrl_pkg holds the opcode constants, the ALU_op constants, the state enum and the IR field bit positions.
- Sub-module cpu_ctrl_decode (combinational) maps opcode to an instruction class (ALU3, UNARY, IMM, MULDIV, LD, LDI, ST, NOP, HALT, ILLEGAL) and to ALU_op.
- Top level holds the state register, next-state logic and the per-step output decode.

## Test plan
- Reset: hold Clear low 3 cycles, assert Clear low again mid-T4 -> all outputs 0 and Run=0 immediately; T0 on the first edge after release.
- add, IR=0x1A920000, MemRdy=1 -> T0–T5 in 6 cycles. T4 shows Grc Rout ZLowIn with ALU_op=00011. T5 shows Gra Rin.
- ld, IR=0x00800065, MemRdy low 2 cycles in T1 and 3 cycles in T6 -> 13 cycles total. PCin pulses once. MDRin fires only in the MemRdy cycles. T7 shows Gra Rin.
- mul, IR=0x71880000 -> T5 shows LOin, T6 shows HIin, ALU_op=01110, 7 cycles.
- halt (IR=0xD8000000), illegal opcode 11111, and Stop=1 during an add -> HALT with Run=0. The add still completes T5 first. Stays in HALT until Clear.
- st, IR=0x10800065, MemRdy=0 for 4 cycles in T7 -> Write held 5 cycles, Read=0 throughout T6–T7, then T0.
